// File: rtl/img_overlay_ctrl.sv
// Double-buffered image overlay: the write side fills the hidden bank while the
// display side reads the shown bank inside a movable window over a background.
module img_overlay_ctrl #(
   parameter int unsigned H_VALID = 480,
   parameter int unsigned V_VALID = 272,
   parameter int unsigned IMG_W   = 98,
   parameter int unsigned IMG_H   = 98,
   parameter int unsigned BARS    = 10
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        pi_flag,
   input  logic [15:0] pi_data,
   input  logic        pi_sof,
   input  logic        pix_en,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic [9:0]  img_x0,
   input  logic [9:0]  img_y0,
   input  logic [1:0]  bg_mode,
   input  logic [15:0] bg_color,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic        wr_frame_done,
   output logic        rd_bank
);
   localparam int unsigned IMG_SIZE = IMG_W * IMG_H;
   localparam int unsigned AW       = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam int unsigned X0_MAX   = H_VALID - IMG_W;
   localparam int unsigned Y0_MAX   = V_VALID - IMG_H;
   localparam int unsigned BAR_W    = H_VALID / BARS;

   logic [15:0]   mem0 [IMG_SIZE];
   logic [15:0]   mem1 [IMG_SIZE];
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          swap_pend;
   logic          img_ready;
   logic [9:0]    x0;
   logic [9:0]    y0;

   logic [AW-1:0] wr_ptr_c;
   logic          wrap_c;
   logic          frame_end_c;
   logic          in_range_c;
   logic          in_win_c;
   logic [9:0]    bar_idx_c;
   logic [15:0]   bg_c;

   // A start-of-image strobe forces the current write to address 0
   always_comb begin
      wr_ptr_c = pi_sof ? '0 : wr_addr;
      wrap_c   = pi_flag && (wr_ptr_c == AW'(IMG_SIZE - 1));
   end

   always_ff @(posedge sys_clk) begin
      if (pi_flag) begin
         if (rd_bank) mem0[wr_ptr_c] <= pi_data;
         else         mem1[wr_ptr_c] <= pi_data;
      end
   end

   // Write pointer and bank swap; a wrap landing on frame end swaps immediately
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_addr       <= '0;
         wr_frame_done <= 1'b0;
         rd_bank       <= 1'b0;
         swap_pend     <= 1'b0;
         img_ready     <= 1'b0;
      end else begin
         wr_frame_done <= wrap_c;
         if (pi_flag)     wr_addr <= wrap_c ? '0 : wr_ptr_c + AW'(1);
         else if (pi_sof) wr_addr <= '0;
         if (frame_end_c && (swap_pend || wrap_c)) begin
            rd_bank   <= ~rd_bank;
            swap_pend <= 1'b0;
            img_ready <= 1'b1;
         end else if (wrap_c) begin
            swap_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      frame_end_c = pix_en && (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
      in_range_c  = (pix_x < 10'(H_VALID)) && (pix_y < 10'(V_VALID));
      in_win_c    = in_range_c
                 && (pix_x >= x0) && (11'(pix_x) < 11'(x0) + 11'(IMG_W))
                 && (pix_y >= y0) && (11'(pix_y) < 11'(y0) + 11'(IMG_H));
   end

   // Background generator
   always_comb begin
      bar_idx_c = pix_x / 10'(BAR_W);
      bg_c      = 16'h0000;
      case (bg_mode)
         2'd0: begin
            if (bar_idx_c < 10'(BARS)) begin
               case (bar_idx_c)
                  10'd0:   bg_c = 16'hF800;
                  10'd1:   bg_c = 16'hFC00;
                  10'd2:   bg_c = 16'hFFE0;
                  10'd3:   bg_c = 16'h07E0;
                  10'd4:   bg_c = 16'h07FF;
                  10'd5:   bg_c = 16'h001F;
                  10'd6:   bg_c = 16'hF81F;
                  10'd7:   bg_c = 16'h0000;
                  10'd8:   bg_c = 16'hFFFF;
                  10'd9:   bg_c = 16'hD69A;
                  default: bg_c = 16'h0000;
               endcase
            end
         end
         2'd1:    bg_c = bg_color;
         2'd2:    bg_c = ((pix_x[4:0] == 5'd0) || (pix_y[4:0] == 5'd0)) ? 16'hFFFF : 16'h0000;
         default: bg_c = 16'h0000;
      endcase
   end

   // Display pipeline: the RAM read lands directly in the output register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pix_data  <= 16'h0000;
         pix_valid <= 1'b0;
         rd_addr   <= '0;
         x0        <= 10'(X0_MAX / 2);
         y0        <= 10'(Y0_MAX / 2);
      end else begin
         pix_valid <= pix_en;
         if (pix_en) begin
            if (!in_range_c)                pix_data <= 16'h0000;
            else if (in_win_c && img_ready) pix_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
            else                            pix_data <= bg_c;
         end
         if (frame_end_c) begin
            rd_addr <= '0;
            x0      <= (img_x0 > 10'(X0_MAX)) ? 10'(X0_MAX) : img_x0;
            y0      <= (img_y0 > 10'(Y0_MAX)) ? 10'(Y0_MAX) : img_y0;
         end else if (pix_en && in_win_c) begin
            rd_addr <= (rd_addr == AW'(IMG_SIZE - 1)) ? '0 : rd_addr + AW'(1);
         end
      end
   end
endmodule

// File: tb/tb_img_overlay_ctrl.sv
// Bench for img_overlay_ctrl: coordinate-based reference model checked every
// cycle, plus literal pixel values at the interesting points.
module tb_img_overlay_ctrl;
   localparam int H  = 480;
   localparam int V  = 272;
   localparam int IW = 98;
   localparam int IH = 98;
   localparam int NB = 10;
   localparam int SZ = IW * IH;
   localparam logic [15:0] PAL [10] = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
                                        16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A};

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        pi_flag   = 1'b0;
   logic [15:0] pi_data   = 16'h0000;
   logic        pi_sof    = 1'b0;
   logic        pix_en    = 1'b0;
   logic [9:0]  pix_x     = 10'd0;
   logic [9:0]  pix_y     = 10'd0;
   logic [9:0]  img_x0    = 10'd191;
   logic [9:0]  img_y0    = 10'd87;
   logic [1:0]  bg_mode   = 2'd0;
   logic [15:0] bg_color  = 16'h0000;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        wr_frame_done;
   logic        rd_bank;

   int n_cmp = 0;
   int n_bad = 0;
   bit run   = 1'b0;

   // Reference model state
   logic [15:0] mbank [2][SZ];
   int          m_bank  = 0;
   int          m_wa    = 0;
   int          m_x0    = (H - IW) / 2;
   int          m_y0    = (V - IH) / 2;
   bit          m_ready = 1'b0;
   bit          m_pend  = 1'b0;
   logic [15:0] e_data  = 16'h0000;
   logic        e_valid = 1'b0;
   logic        e_done  = 1'b0;

   always #5 sys_clk = ~sys_clk;

   img_overlay_ctrl #(
      .H_VALID(H), .V_VALID(V), .IMG_W(IW), .IMG_H(IH), .BARS(NB)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .pi_flag(pi_flag), .pi_data(pi_data), .pi_sof(pi_sof),
      .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y),
      .img_x0(img_x0), .img_y0(img_y0),
      .bg_mode(bg_mode), .bg_color(bg_color),
      .pix_data(pix_data), .pix_valid(pix_valid),
      .wr_frame_done(wr_frame_done), .rd_bank(rd_bank)
   );

   function automatic logic [15:0] bg_of(input logic [1:0] mode, input logic [15:0] col,
                                         input int px, input int py);
      int idx;
      idx = px / (H / NB);
      case (mode)
         2'd0:    return (idx < NB) ? PAL[idx] : 16'h0000;
         2'd1:    return col;
         2'd2:    return ((px % 32 == 0) || (py % 32 == 0)) ? 16'hFFFF : 16'h0000;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Window pixels are addressed by their offset from the latched origin
   always @(posedge sys_clk or negedge sys_rst_n) begin : model
      int a;
      int px;
      int py;
      bit last;
      if (!sys_rst_n) begin
         m_bank = 0; m_wa = 0; m_ready = 1'b0; m_pend = 1'b0;
         m_x0 = (H - IW) / 2; m_y0 = (V - IH) / 2;
         e_data = 16'h0000; e_valid = 1'b0; e_done = 1'b0;
      end else begin
         a    = pi_sof ? 0 : m_wa;
         last = pi_flag && (a == SZ - 1);
         px   = int'(pix_x);
         py   = int'(pix_y);
         e_done  = last;
         e_valid = pix_en;
         if (pix_en) begin
            if (px >= H || py >= V)
               e_data = 16'h0000;
            else if (m_ready && px >= m_x0 && px < m_x0 + IW && py >= m_y0 && py < m_y0 + IH)
               e_data = mbank[m_bank][(py - m_y0) * IW + (px - m_x0)];
            else
               e_data = bg_of(bg_mode, bg_color, px, py);
         end
         if (pi_flag) begin
            mbank[1 - m_bank][a] = pi_data;
            m_wa = (a + 1) % SZ;
         end else if (pi_sof) begin
            m_wa = 0;
         end
         if (pix_en && px == H - 1 && py == V - 1) begin
            m_x0 = (int'(img_x0) > H - IW) ? H - IW : int'(img_x0);
            m_y0 = (int'(img_y0) > V - IH) ? V - IH : int'(img_y0);
            if (m_pend || last) begin
               m_bank  = 1 - m_bank;
               m_pend  = 1'b0;
               m_ready = 1'b1;
            end
         end else if (last) begin
            m_pend = 1'b1;
         end
      end
   end

   always @(negedge sys_clk) begin
      if (run) begin
         check("pix_valid", 16'(pix_valid), 16'(e_valid));
         check("pix_data", pix_data, e_data);
         check("wr_frame_done", 16'(wr_frame_done), 16'(e_done));
         check("rd_bank", 16'(rd_bank), 16'(m_bank));
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic show(input int x, input int y);
      pix_en = 1'b1;
      pix_x  = 10'(x);
      pix_y  = 10'(y);
      tick();
      pix_en = 1'b0;
   endtask

   task automatic pin(input string name, input logic [15:0] lit);
      check(name, pix_data, lit);
      check({name, "_model"}, e_data, lit);
   endtask

   task automatic wr(input logic sof, input logic [15:0] d);
      pi_flag = 1'b1;
      pi_sof  = sof;
      pi_data = d;
      tick();
      pi_flag = 1'b0;
      pi_sof  = 1'b0;
   endtask

   // Raster-scan the window with one bracketing pixel on each side of every line
   task automatic scan_win(input int x0, input int y0, input int gap_idx,
                           output logic [15:0] left, output logic [15:0] first,
                           output logic [15:0] last);
      int k;
      logic [15:0] hold;
      k = 0; left = '0; first = '0; last = '0;
      for (int y = y0; y < y0 + IH; y++) begin
         for (int x = x0 - 1; x <= x0 + IW; x++) begin
            if (x >= x0 && x < x0 + IW) begin
               if (k == gap_idx) begin
                  hold = pix_data;
                  tick();
                  check("gap_valid", 16'(pix_valid), 16'h0000);
                  tick();
                  tick();
                  check("gap_hold", pix_data, hold);
               end
               k++;
            end
            show(x, y);
            if (x == x0 - 1 && y == y0)            left  = pix_data;
            if (x == x0 && y == y0)                first = pix_data;
            if (x == x0 + IW - 1 && y == y0 + IH - 1) last = pix_data;
         end
      end
   endtask

   initial begin
      logic [15:0] l;
      logic [15:0] f;
      logic [15:0] z;
      tick();
      run = 1'b1;
      tick();
      sys_rst_n = 1'b1;
      check("rst_pix_data", pix_data, 16'h0000);
      check("rst_pix_valid", 16'(pix_valid), 16'h0000);
      check("rst_rd_bank", 16'(rd_bank), 16'h0000);

      // Colour bars, no image yet
      show(0, 0);     pin("bar0", 16'hF800);
      show(48, 0);    pin("bar1", 16'hFC00);
      show(479, 0);   pin("bar9", 16'hD69A);
      show(191, 87);  pin("hidden_win", 16'h07E0);
      show(H - 1, V - 1);
      check("bank_a", 16'(rd_bank), 16'h0000);

      // Solid image, swapped in at the next frame end
      for (int a = 0; a < SZ; a++) begin
         wr(a == 0, 16'h1234);
         if (a == SZ - 1)      check("done_pulse", 16'(wr_frame_done), 16'h0001);
         else if (a == SZ - 2) check("done_early", 16'(wr_frame_done), 16'h0000);
      end
      tick();
      check("done_drop", 16'(wr_frame_done), 16'h0000);
      check("bank_pre", 16'(rd_bank), 16'h0000);
      show(H - 1, V - 1);
      check("bank_b", 16'(rd_bank), 16'h0001);
      scan_win(191, 87, -1, l, f, z);
      check("b_left", l, 16'h07E0);
      check("b_first", f, 16'h1234);
      check("b_last", z, 16'h1234);
      show(H - 1, V - 1);

      // Ramp image whose final write coincides with frame end; clamped origin
      img_x0 = 10'd450; img_y0 = 10'd5; bg_mode = 2'd1; bg_color = 16'h0BAD;
      for (int a = 0; a < SZ - 1; a++) wr(a == 0, 16'(a) ^ 16'hA500);
      pi_flag = 1'b1; pi_data = 16'(SZ - 1) ^ 16'hA500;
      pix_en = 1'b1; pix_x = 10'(H - 1); pix_y = 10'(V - 1);
      tick();
      pi_flag = 1'b0; pix_en = 1'b0;
      check("swap_on_wrap", 16'(rd_bank), 16'h0000);
      check("wrap_done", 16'(wr_frame_done), 16'h0001);
      scan_win(382, 5, 150, l, f, z);
      check("c_left", l, 16'h0BAD);
      check("c_first", f, 16'hA500);
      check("c_last", z, 16'h8083);
      show(H - 1, V - 1);
      check("no_reswap", 16'(rd_bank), 16'h0000);
      show(382, 5);   pin("rd_restart", 16'hA500);
      show(H - 1, V - 1);

      // Grid background and write restarts
      bg_mode = 2'd2;
      show(32, 7);    pin("grid_on", 16'hFFFF);
      show(33, 7);    pin("grid_off", 16'h0000);
      for (int a = 0; a < 5; a++) wr(a == 0, 16'hDEAD);
      pi_sof = 1'b1;
      tick();
      pi_sof = 1'b0;
      check("sof_no_done", 16'(wr_frame_done), 16'h0000);
      for (int a = 0; a < 10; a++) wr(1'b0, 16'hDEAD);
      wr(1'b1, 16'hBEEF);
      for (int a = 1; a < SZ; a++) wr(1'b0, 16'(a) ^ 16'h5A5A);
      check("e_done", 16'(wr_frame_done), 16'h0001);
      show(H - 1, V - 1);
      check("bank_e", 16'(rd_bank), 16'h0001);
      show(382, 5);   pin("sof_addr0", 16'hBEEF);
      show(383, 5);   pin("sof_addr1", 16'h5A5B);
      show(H - 1, V - 1);

      // Reset in the middle of a write hides the image again
      bg_mode = 2'd1; bg_color = 16'h0BAD;
      for (int a = 0; a < 7; a++) wr(a == 0, 16'hCAFE);
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_data", pix_data, 16'h0000);
      check("mid_rst_valid", 16'(pix_valid), 16'h0000);
      check("mid_rst_bank", 16'(rd_bank), 16'h0000);
      tick();
      tick();
      sys_rst_n = 1'b1;
      show(191, 87);  pin("hidden_after_rst", 16'h0BAD);

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/img_overlay_ctrl.md
IMG_OVERLAY_CTRL -- requirements
Module: img_overlay_ctrl

Interface
REQ-001 SHALL have parameter H_VALID, default 480, active pixels per line.
REQ-002 SHALL have parameter V_VALID, default 272, active lines per frame.
REQ-003 SHALL have parameter IMG_W, default 98, image width in pixels.
REQ-004 SHALL have parameter IMG_H, default 98, image height in lines; IMG_SIZE = IMG_W*IMG_H, address width = clog2(IMG_SIZE).
REQ-005 SHALL have parameter BARS, default 10, number of colour bars, legal range 1..10.
REQ-006 SHALL have port sys_clk, input, 1, single clock for the write and display sides; all logic rising-edge.
REQ-007 SHALL have port sys_rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port pi_flag, input, 1, write strobe for pi_data.
REQ-009 SHALL have port pi_data, input, 16, RGB565 image pixel.
REQ-010 SHALL have port pi_sof, input, 1, start of image write: restarts the write address.
REQ-011 SHALL have port pix_en, input, 1, display pixel strobe.
REQ-012 SHALL have ports pix_x and pix_y, input, 10 each, display coordinates.
REQ-013 SHALL have ports img_x0 and img_y0, input, 10 each, requested image top-left position.
REQ-014 SHALL have port bg_mode, input, 2, background select.
REQ-015 SHALL have port bg_color, input, 16, solid background colour.
REQ-016 SHALL have port pix_data, output, 16, registered pixel colour.
REQ-017 SHALL have port pix_valid, output, 1, pix_data qualifier.
REQ-018 SHALL have port wr_frame_done, output, 1, one-cycle pulse when an image write completes.
REQ-019 SHALL have port rd_bank, output, 1, index of the displayed buffer.

Function
REQ-020 SHALL contain two internal IMG_SIZE x 16 synchronous-read RAM banks; writes go only to bank ~rd_bank.
REQ-021 When pi_flag=1, SHALL write pi_data at wr_addr and then advance wr_addr; if pi_sof=1 in the same cycle, the write address is 0 and wr_addr becomes 1.
REQ-022 When a write lands at IMG_SIZE-1, SHALL wrap wr_addr to 0, pulse wr_frame_done for one cycle, and set swap_pend.
REQ-023 When pi_sof=1 and pi_flag=0, SHALL set wr_addr to 0 with no write and no wr_frame_done.
REQ-024 Frame end is defined as pix_en=1 with pix_x=H_VALID-1 and pix_y=V_VALID-1.
REQ-025 At frame end, SHALL latch x0 = min(img_x0, H_VALID-IMG_W) and y0 = min(img_y0, V_VALID-IMG_H); the latched values take effect from the next pixel.
REQ-026 At frame end, SHALL reset rd_addr to 0.
REQ-027 At frame end with swap_pend=1, or with a wrap occurring in the same cycle, SHALL toggle rd_bank, clear swap_pend, and set img_ready=1.
REQ-028 SHALL compute in_win = x0 <= pix_x < x0+IMG_W and y0 <= pix_y < y0+IMG_H.
REQ-029 When pix_en=1 and in_win=1, SHALL read the rd_bank RAM at rd_addr and advance rd_addr, wrapping from IMG_SIZE-1 to 0.
REQ-030 SHALL have a latency of exactly 1 cycle: pix_valid(t+1) = pix_en(t); pix_data(t+1) corresponds to pix_x/pix_y at t.
REQ-031 SHALL drive pix_data(t+1) with the RAM output when in_win(t)=1, pix_en(t)=1 and img_ready=1; otherwise with the background colour.
REQ-032 bg_mode 0, colour bars: bar index = pix_x / (H_VALID/BARS); palette by index is F800, FC00, FFE0, 07E0, 07FF, 001F, F81F, 0000, FFFF, D69A; an index >= BARS gives 0000.
REQ-033 bg_mode 1 SHALL output bg_color.
REQ-034 bg_mode 2, grid: SHALL output FFFF when pix_x[4:0]=0 or pix_y[4:0]=0, otherwise 0000.
REQ-035 bg_mode 3 SHALL output 0000.
REQ-036 When pix_x >= H_VALID or pix_y >= V_VALID, SHALL output 0000 and SHALL NOT advance rd_addr.
REQ-037 When pix_en=0, SHALL hold pix_data and SHALL NOT advance rd_addr.

Reset
REQ-038 While sys_rst_n=0, SHALL hold pix_data=0, pix_valid=0, wr_frame_done=0, rd_bank=0, img_ready=0, swap_pend=0, wr_addr=0, rd_addr=0.
REQ-039 While sys_rst_n=0, SHALL hold x0=(H_VALID-IMG_W)/2 and y0=(V_VALID-IMG_H)/2, i.e. 191 and 87 by default.
REQ-040 SHALL NOT clear RAM contents on reset; a mid-frame reset SHALL abort any partial write, and the image SHALL stay hidden until the next completed write and swap.

Verification
REQ-041 Reset, then scan a full frame with bg_mode=0 and no writes -> pix_x=0 gives F800, pix_x=48 gives FC00, pix_x=479 gives D69A; no image pixels appear.
REQ-042 Write 9604 pixels of value 0x1234 -> wr_frame_done pulses on the write of address 9603; at the next frame end rd_bank becomes 1, and the following frame shows 0x1234 at (191,87) through (288,184) and background at (190,87).
REQ-043 Set img_x0=450, img_y0=5 before a frame end -> the window spans x 382..479, y 5..102; rd_addr equals 9603 at the last window pixel and 0 after the frame end.
REQ-044 Drive the wrap write on the same cycle as frame end -> rd_bank toggles on that cycle and swap_pend ends at 0.
REQ-045 Deassert pix_en for 3 cycles inside the window -> pix_valid is low 1 cycle later, pix_data holds, and rd_addr does not advance.
REQ-046 Set bg_mode=2 -> pix_data is FFFF at (32,7) and 0000 at (33,7); assert pi_sof mid-write -> the next write lands at address 0.
